shift_window_ctrl: RTL and testbench

- Sequencing controller for a depth-PIPE_DEPTH data/status shift-register window in the Ethernet parser byte path.
- Converts an upstream valid/ready byte stream with a last marker into `shift_en` and bubble-insert strobes for the window.
- Downstream sees a valid oldest tap only when the full lookahead window is loaded, or while draining after a frame end.
- Handles stall, frame-end flush and abort.

---
 rtl/shift_window_ctrl_pkg.sv | 5 +
 rtl/shift_window_ctrl_if.sv | 19 +
 rtl/shift_window_ctrl_shift_reg_en.sv | 22 ++
 rtl/shift_window_ctrl.sv | 59 +++++
 tb/tb_shift_window_ctrl.sv | 115 +++++++++++
 5 files changed

// File: rtl/shift_window_ctrl_pkg.sv
// shift_window_ctrl_pkg: shared state encoding and status-bit constants for the window controller
package shift_window_ctrl_pkg;
  typedef enum logic [1:0] {FILL, RUN, FLUSH} win_state_e;
  localparam int ST_VALID_IDX = 0;
endpackage

// File: rtl/shift_window_ctrl_if.sv
// shift_window_ctrl_if: upstream, downstream and window-control signals of the window controller
interface shift_window_ctrl_if #(parameter int PIPE_DEPTH = 4);
  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic abort;
  logic shift_en;
  logic bubble;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic [CNT_W-1:0] fill_cnt;
  logic flushing;
  modport master (output in_valid, in_last, abort, out_ready,
                  input in_ready, shift_en, bubble, out_valid, out_last, fill_cnt, flushing);
  modport slave (input in_valid, in_last, abort, out_ready,
                 output in_ready, shift_en, bubble, out_valid, out_last, fill_cnt, flushing);
endinterface

// File: rtl/shift_window_ctrl_shift_reg_en.sv
// shift_reg_en: enabled shift register, index 0 newest, with sync clear and optional async reset
module shift_reg_en
  import shift_window_ctrl_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH = 4,
  parameter bit RST_EN = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DEPTH-1:0][DATA_W-1:0] q
);
  // shift toward the oldest tap; clear wins over a same-cycle shift
  always_ff @(posedge clk or posedge rst)
    if (RST_EN && rst) q <= {DEPTH{RST_VAL}};
    else if (clr) q <= {DEPTH{RST_VAL}};
    else if (en) q <= {q[DEPTH-2:0], data_i};
endmodule

// File: rtl/shift_window_ctrl.sv
// shift_window_ctrl: turns a valid/ready byte stream into shift/bubble strobes for a lookahead window
module shift_window_ctrl
  import shift_window_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W = $clog2(PIPE_DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  shift_window_ctrl_if.slave bus
);
  win_state_e st;
  logic [CNT_W-1:0] cnt;
  logic [PIPE_DEPTH-1:0][0:0] occ;
  logic live, tail, acc, cons, clr;
  // handshake and window strobes; everything is held low during reset or abort
  always_comb begin
    live = !rst && !bus.abort;
    tail = occ[PIPE_DEPTH-1][0];
    bus.in_ready = live && (st == FILL || (st == RUN && bus.out_ready));
    acc = bus.in_valid && bus.in_ready;
    bus.out_valid = live && (st == RUN || (st == FLUSH && tail));
    bus.out_last = st == FLUSH && bus.out_valid && cnt == CNT_W'(1);
    bus.shift_en = live && (st == FLUSH ? (!tail || bus.out_ready) : acc);
    bus.bubble = bus.shift_en && st == FLUSH;
    bus.flushing = st == FLUSH;
    bus.fill_cnt = cnt;
    cons = st == FLUSH && tail && bus.out_ready;
    clr = bus.abort || (cons && cnt == CNT_W'(1));
  end
  // fill/run/flush sequencing and the valid-entry count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= FILL;
      cnt <= '0;
    end else if (bus.abort) begin
      st <= FILL;
      cnt <= '0;
    end else
      case (st)
        FILL: if (acc) begin
          cnt <= cnt + CNT_W'(1);
          st <= bus.in_last ? FLUSH : cnt == CNT_W'(PIPE_DEPTH - 1) ? RUN : FILL;
        end
        RUN: if (acc && bus.in_last) st <= FLUSH;
        default: if (cons) begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) st <= FILL;
        end
      endcase
  shift_reg_en #(.DATA_W(1), .DEPTH(PIPE_DEPTH), .RST_EN(1'b1), .RST_VAL(1'b0)) u_occ (
    .clk(clk),
    .rst(rst),
    .en(bus.shift_en),
    .clr(clr),
    .data_i(!bus.bubble),
    .q(occ)
  );
endmodule

// File: tb/tb_shift_window_ctrl.sv
// tb_shift_window_ctrl: directed vector bench for the window controller at depth 4
module tb_shift_window_ctrl;
  typedef struct {
    logic vld, last, abt, ordy;
    logic [8:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[24];
  shift_window_ctrl_if #(.PIPE_DEPTH(4)) bus ();
  shift_window_ctrl #(.PIPE_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [8:0] obs();
    return {bus.in_ready, bus.shift_en, bus.bubble, bus.out_valid, bus.out_last, bus.fill_cnt, bus.flushing};
  endfunction
  function automatic logic [8:0] e(bit rdy, bit sh, bit bub, bit ov, bit ol, int c, bit fl);
    return {rdy, sh, bub, ov, ol, 3'(c), fl};
  endfunction
  task automatic chk(string name, logic [8:0] exp);
    n_vec++;
    if (obs() !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy/sh/bub/ov/ol/cnt/fl=%b want %b", name, obs(), exp);
    end
  endtask
  task automatic cyc(string name, logic vld, logic last, logic abt, logic ordy, logic [8:0] exp);
    bus.in_valid = vld;
    bus.in_last = last;
    bus.abort = abt;
    bus.out_ready = ordy;
    #3;
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic run_tbl(int lo, int hi);
    for (int i = lo; i <= hi; i++)
      cyc($sformatf("tbl[%0d]", i), tbl[i].vld, tbl[i].last, tbl[i].abt, tbl[i].ordy, tbl[i].exp);
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 1, e(1, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 0, 0, 1, e(1, 1, 0, 0, 0, 1, 0)};
    tbl[2]  = '{1, 0, 0, 1, e(1, 1, 0, 0, 0, 2, 0)};
    tbl[3]  = '{1, 0, 0, 1, e(1, 1, 0, 0, 0, 3, 0)};
    tbl[4]  = '{1, 0, 0, 1, e(1, 1, 0, 1, 0, 4, 0)};
    tbl[5]  = '{1, 1, 0, 1, e(1, 1, 0, 1, 0, 4, 0)};
    tbl[6]  = '{0, 0, 0, 1, e(0, 1, 1, 1, 0, 4, 1)};
    tbl[7]  = '{0, 0, 0, 1, e(0, 1, 1, 1, 0, 3, 1)};
    tbl[8]  = '{0, 0, 0, 1, e(0, 1, 1, 1, 0, 2, 1)};
    tbl[9]  = '{0, 0, 0, 1, e(0, 1, 1, 1, 1, 1, 1)};
    tbl[10] = '{0, 0, 0, 1, e(1, 0, 0, 0, 0, 0, 0)};
    tbl[11] = '{1, 0, 0, 1, e(1, 1, 0, 0, 0, 0, 0)};
    tbl[12] = '{1, 1, 0, 1, e(1, 1, 0, 0, 0, 1, 0)};
    tbl[13] = '{0, 0, 0, 1, e(0, 1, 1, 0, 0, 2, 1)};
    tbl[14] = '{0, 0, 0, 1, e(0, 1, 1, 0, 0, 2, 1)};
    tbl[15] = '{0, 0, 0, 1, e(0, 1, 1, 1, 0, 2, 1)};
    tbl[16] = '{0, 0, 0, 1, e(0, 1, 1, 1, 1, 1, 1)};
    tbl[17] = '{0, 0, 0, 1, e(1, 0, 0, 0, 0, 0, 0)};
    tbl[18] = '{1, 1, 0, 1, e(1, 1, 0, 0, 0, 0, 0)};
    tbl[19] = '{0, 0, 0, 1, e(0, 1, 1, 0, 0, 1, 1)};
    tbl[20] = '{0, 0, 0, 1, e(0, 1, 1, 0, 0, 1, 1)};
    tbl[21] = '{0, 0, 0, 1, e(0, 1, 1, 0, 0, 1, 1)};
    tbl[22] = '{0, 0, 0, 1, e(0, 1, 1, 1, 1, 1, 1)};
    tbl[23] = '{0, 0, 0, 1, e(1, 0, 0, 0, 0, 0, 0)};
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("reset_state", e(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_tbl(0, 23);
    for (int i = 0; i < 4; i++) cyc("bp_run_fill", 1, 0, 0, 1, e(1, 1, 0, 0, 0, i, 0));
    for (int i = 0; i < 5; i++) cyc("bp_run_hold", 1, 0, 0, 0, e(0, 0, 0, 1, 0, 4, 0));
    for (int i = 0; i < 3; i++) cyc("bp_run_release", 1, 0, 0, 1, e(1, 1, 0, 1, 0, 4, 0));
    cyc("bp_run_last", 1, 1, 0, 1, e(1, 1, 0, 1, 0, 4, 0));
    cyc("bp_fl_c4_r1", 0, 0, 0, 1, e(0, 1, 1, 1, 0, 4, 1));
    cyc("bp_fl_c3_r0", 0, 0, 0, 0, e(0, 0, 0, 1, 0, 3, 1));
    cyc("bp_fl_c3_r1", 0, 0, 0, 1, e(0, 1, 1, 1, 0, 3, 1));
    cyc("bp_fl_c2_r0", 0, 0, 0, 0, e(0, 0, 0, 1, 0, 2, 1));
    cyc("bp_fl_c2_r1", 0, 0, 0, 1, e(0, 1, 1, 1, 0, 2, 1));
    cyc("bp_fl_c1_r0", 0, 0, 0, 0, e(0, 0, 0, 1, 1, 1, 1));
    cyc("bp_fl_c1_r1", 0, 0, 0, 1, e(0, 1, 1, 1, 1, 1, 1));
    cyc("bp_fl_done", 0, 0, 0, 1, e(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("ab_fill", 1, 0, 0, 1, e(1, 1, 0, 0, 0, i, 0));
    cyc("ab_fill_abort", 1, 0, 1, 1, e(0, 0, 0, 0, 0, 3, 0));
    cyc("ab_fill_after", 0, 0, 0, 1, e(1, 0, 0, 0, 0, 0, 0));
    run_tbl(0, 10);
    cyc("ab_fl_byte", 1, 1, 0, 1, e(1, 1, 0, 0, 0, 0, 0));
    cyc("ab_fl_bubble", 0, 0, 0, 1, e(0, 1, 1, 0, 0, 1, 1));
    cyc("ab_fl_abort", 0, 0, 1, 1, e(0, 0, 0, 0, 0, 1, 1));
    cyc("ab_fl_after", 0, 0, 0, 1, e(1, 0, 0, 0, 0, 0, 0));
    run_tbl(0, 10);
    cyc("rst_byte", 1, 1, 0, 1, e(1, 1, 0, 0, 0, 0, 0));
    cyc("rst_bubble", 0, 0, 0, 1, e(0, 1, 1, 0, 0, 1, 1));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_drop", e(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_release", e(1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    run_tbl(0, 10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
